// File: rtl/tone_playback_ctrl_pkg.sv
// Shared definitions for the TinyTone melody playback path: note codes,
// controller states and melody-entry field helpers.
package tone_playback_ctrl_pkg;

    localparam logic [5:0] REST_CODE = 6'd0;
    localparam logic [5:0] END_CODE  = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_NOTE  = 3'd2,
        ST_GAP   = 3'd3,
        ST_PAUSE = 3'd4
    } state_e;

    function automatic logic [5:0] entry_note(input logic [7:0] entry);
        return entry[5:0];
    endfunction

    function automatic logic [1:0] entry_len(input logic [7:0] entry);
        return entry[7:6];
    endfunction

endpackage

// File: rtl/tone_playback_ctrl_duration_counter.sv
// Loadable down counter timing one melody note, with zero and
// compare-against-threshold flags used for the articulation gap.
module tone_duration_counter
    import tone_playback_ctrl_pkg::*;
#(
    parameter int unsigned W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] cmp_val_i,
    output logic         zero_o,
    output logic         cmp_le_o,
    output logic         cmp_ge_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o   = (cnt_q == '0);
    assign cmp_le_o = (cnt_q <= cmp_val_i);
    assign cmp_ge_o = (cnt_q >= cmp_val_i);

endmodule

// File: rtl/tone_playback_ctrl.sv
// Melody playback controller: walks the melody ROM, times each note from the
// selected tempo, and drives note index plus PWM gate with pause/stop/loop control.
module tone_playback_ctrl
    import tone_playback_ctrl_pkg::*;
#(
    parameter int unsigned        AW         = 6,
    parameter int unsigned        BEAT_BW    = 24,
    parameter logic [BEAT_BW-1:0] BEAT_SLOW  = 24'd4800000,
    parameter logic [BEAT_BW-1:0] BEAT_MED   = 24'd2400000,
    parameter logic [BEAT_BW-1:0] BEAT_FAST  = 24'd1200000,
    parameter logic [BEAT_BW-1:0] GAP_CYCLES = 24'd240000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          pause_i,
    input  logic          loop_en_i,
    input  logic [1:0]    tempo_sel_i,
    input  logic [7:0]    melody_data_i,
    output logic [AW-1:0] melody_addr_o,
    output logic [5:0]    note_index_o,
    output logic          gate_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int unsigned   CW        = BEAT_BW + 2;
    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam logic [CW-1:0] GAP_W     = CW'(GAP_CYCLES);

    state_e        state_q, state_d;
    state_e        saved_q, saved_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [5:0]    note_q, note_d;
    logic          gate_q, gate_d;
    logic          done_q, done_d;

    logic [BEAT_BW-1:0] beat;
    logic [CW-1:0]      beat_x1, beat_x2, scaled, load_val;
    logic               cnt_clr, cnt_load, cnt_en;
    logic               cnt_zero, cnt_le_gap, cnt_ge_gap;
    logic [5:0]         fetch_note;

    assign fetch_note = entry_note(melody_data_i);

    always_comb begin
        unique case (tempo_sel_i)
            2'd1:    beat = BEAT_MED;
            2'd2:    beat = BEAT_FAST;
            default: beat = BEAT_SLOW;
        endcase
    end

    // (len+1) beats built from shifts and one add, keeping multipliers out of the path
    assign beat_x1 = {2'b00, beat};
    assign beat_x2 = {1'b0, beat, 1'b0};

    always_comb begin
        unique case (entry_len(melody_data_i))
            2'd0:    scaled = beat_x1;
            2'd1:    scaled = beat_x2;
            2'd2:    scaled = beat_x2 + beat_x1;
            default: scaled = {beat, 2'b00};
        endcase
    end

    assign load_val = scaled - CW'(1);

    tone_duration_counter #(
        .W (CW)
    ) u_dur_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (load_val),
        .cmp_val_i  (GAP_W),
        .zero_o     (cnt_zero),
        .cmp_le_o   (cnt_le_gap),
        .cmp_ge_o   (cnt_ge_gap)
    );

    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        addr_d   = addr_q;
        note_d   = note_q;
        gate_d   = gate_q;
        done_d   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        if (stop_i) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            note_d  = '0;
            gate_d  = 1'b0;
            cnt_clr = 1'b1;
        end else if (state_q == ST_IDLE) begin
            if (start_i) begin
                state_d = ST_FETCH;
                addr_d  = '0;
            end
        end else if (pause_i) begin
            if (state_q != ST_PAUSE) begin
                saved_d = state_q;
            end
            state_d = ST_PAUSE;
            gate_d  = 1'b0;
        end else if (start_i) begin
            state_d = ST_FETCH;
            addr_d  = '0;
            gate_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (fetch_note == END_CODE) begin
                        // A lone end marker at address 0 must still terminate when looping
                        if (loop_en_i && (addr_q != '0)) begin
                            addr_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        note_d   = fetch_note;
                        cnt_load = 1'b1;
                        gate_d   = (fetch_note != REST_CODE) && (load_val >= GAP_W);
                        state_d  = ST_NOTE;
                    end
                end
                ST_NOTE, ST_GAP: begin
                    if (cnt_zero) begin
                        gate_d = 1'b0;
                        if (addr_q == LAST_ADDR) begin
                            if (loop_en_i) begin
                                addr_d  = '0;
                                state_d = ST_FETCH;
                            end else begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            addr_d  = addr_q + AW'(1);
                            state_d = ST_FETCH;
                        end
                    end else begin
                        cnt_en = 1'b1;
                        if ((state_q == ST_NOTE) && cnt_le_gap) begin
                            state_d = ST_GAP;
                            gate_d  = 1'b0;
                        end
                    end
                end
                ST_PAUSE: begin
                    state_d = saved_q;
                    gate_d  = (saved_q == ST_NOTE) && (note_q != REST_CODE) && cnt_ge_gap;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            saved_q <= ST_IDLE;
            addr_q  <= '0;
            note_q  <= '0;
            gate_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            gate_q  <= gate_d;
            done_q  <= done_d;
        end
    end

    assign melody_addr_o = addr_q;
    assign note_index_o  = note_q;
    assign gate_o        = gate_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;

endmodule
